// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle of hazard-detection inputs and pipeline stall/flush
//               controls exchanged between the core and hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   // Hazard sources observed in the pipeline
   logic [4:0]       rs1_addrD;
   logic [4:0]       rs2_addrD;
   logic [4:0]       rdE;
   logic             MemReadE;
   logic             mispredictE;
   logic             dmem_reqM;
   logic             dmem_ready;

   // Pipeline register controls and status
   logic             stallF;
   logic             stallD;
   logic             stallE;
   logic             stallM;
   logic             flushD;
   logic             flushE;
   logic             timeout_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   // Core side: presents hazard sources, consumes controls
   modport master (
      output rs1_addrD, rs2_addrD, rdE, MemReadE, mispredictE, dmem_reqM, dmem_ready,
      input  stallF, stallD, stallE, stallM, flushD, flushE,
      input  timeout_err, stall_cycles, flush_count
   );

   // Hazard controller side
   modport slave (
      input  rs1_addrD, rs2_addrD, rdE, MemReadE, mispredictE, dmem_reqM, dmem_ready,
      output stallF, stallD, stallE, stallM, flushD, flushE,
      output timeout_err, stall_cycles, flush_count
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : RV32 pipeline hazard controller. Generates stall/flush
//               controls for load-use interlocks, EX-stage mispredict
//               recovery and multi-cycle data-memory waits (with sticky
//               timeout detection). Keeps saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  wire logic   clk,
   input  wire logic   rst,
   hazard_ctrl_if.slave hz
);

   // Wide enough to hold MEM_TIMEOUT itself (the saturation value)
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] c_wait_one = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
   localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]   flush_count_q, flush_count_d;

   logic               mem_busy;
   logic               load_use;
   logic               timeout_hit;
   logic               flush_issue;
   logic               stallF_c, stallD_c, stallE_c, stallM_c;
   logic               flushD_c, flushE_c;

   // State, wait counter, sticky error and counters; async clear on rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         wait_cnt_q     <= '0;
         timeout_err_q  <= 1'b0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         timeout_err_q  <= timeout_err_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   // Next-state logic and prioritised stall/flush decode (zero latency)
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_busy    = 1'b0;
      timeout_hit = 1'b0;
      flush_issue = 1'b0;
      stallF_c    = 1'b0;
      stallD_c    = 1'b0;
      stallE_c    = 1'b0;
      stallM_c    = 1'b0;
      flushD_c    = 1'b0;
      flushE_c    = 1'b0;

      // x0 is hard-wired zero, so a load targeting it never creates a hazard
      load_use = hz.MemReadE && (hz.rdE != 5'd0) &&
                 ((hz.rdE == hz.rs1_addrD) || (hz.rdE == hz.rs2_addrD));

      case (state_q)
         ST_RUN: begin
            mem_busy = hz.dmem_reqM && !hz.dmem_ready;
            if (mem_busy) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = c_wait_one;
            end
         end
         ST_MEM_WAIT: begin
            // Request is treated as held while waiting; only ready matters
            mem_busy = !hz.dmem_ready;
            if (hz.dmem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               timeout_hit = (wait_cnt_q == c_wait_max);
               if (wait_cnt_q != c_wait_max) begin
                  wait_cnt_d = wait_cnt_q + c_wait_one;
               end
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase

      // Memory wait freezes everything; a mispredict then kills the
      // wrong-path ID instruction, so a load-use on it is irrelevant
      if (mem_busy) begin
         stallF_c = 1'b1;
         stallD_c = 1'b1;
         stallE_c = 1'b1;
         stallM_c = 1'b1;
      end else if (hz.mispredictE) begin
         flushD_c    = 1'b1;
         flushE_c    = 1'b1;
         flush_issue = 1'b1;
      end else if (load_use) begin
         stallF_c = 1'b1;
         stallD_c = 1'b1;
         flushE_c = 1'b1;
      end

      // While reset is held every control is quiet
      if (rst) begin
         stallF_c    = 1'b0;
         stallD_c    = 1'b0;
         stallE_c    = 1'b0;
         stallM_c    = 1'b0;
         flushD_c    = 1'b0;
         flushE_c    = 1'b0;
         flush_issue = 1'b0;
         timeout_hit = 1'b0;
      end
   end

   // Sticky timeout flag and saturating performance counters
   always_comb begin
      timeout_err_d  = timeout_err_q | timeout_hit;
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stallF_c && (stall_cycles_q != c_cnt_max)) begin
         stall_cycles_d = stall_cycles_q + c_cnt_one;
      end
      if (flush_issue && (flush_count_q != c_cnt_max)) begin
         flush_count_d = flush_count_q + c_cnt_one;
      end
   end

   assign hz.stallF       = stallF_c;
   assign hz.stallD       = stallD_c;
   assign hz.stallE       = stallE_c;
   assign hz.stallM       = stallM_c;
   assign hz.flushD       = flushD_c;
   assign hz.flushE       = flushE_c;
   assign hz.timeout_err  = timeout_err_q;
   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios
//               followed by random traffic, checked against a cycle-level
//               behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
   localparam int MT      = 4;
   localparam int CW      = 4;
   localparam int SAT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // Model: "busy episode" bookkeeping and counters as plain integers
   bit   m_wait;
   int   m_busy_run;
   bit   m_err;
   int   m_stall;
   int   m_flush;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CW)) hz ();

   hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ctl_vec();
      return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE};
   endfunction

   task automatic model_reset();
      m_wait     = 1'b0;
      m_busy_run = 0;
      m_err      = 1'b0;
      m_stall    = 0;
      m_flush    = 0;
   endtask

   // Async reset pulse away from the clock edge; checks happen with no edge
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_ctl", {26'd0, ctl_vec()}, 32'd0);
      chk("rst_err", {31'd0, hz.timeout_err}, 32'd0);
      chk("rst_cnt", {24'd0, hz.stall_cycles, hz.flush_count}, 32'd0);
      #1;
      rst = 1'b0;
   endtask

   // One clock cycle: drive, check combinational controls, clock, check state
   task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic mr, input logic mp, input logic req, input logic rdy);
      bit busy, lu;
      logic [5:0] exp_ctl;
      hz.rs1_addrD   = r1;
      hz.rs2_addrD   = r2;
      hz.rdE         = rd;
      hz.MemReadE    = mr;
      hz.mispredictE = mp;
      hz.dmem_reqM   = req;
      hz.dmem_ready  = rdy;
      #2;
      busy = m_wait ? !rdy : (req && !rdy);
      lu   = mr && (rd != 0) && (rd == r1 || rd == r2);
      if (busy)    exp_ctl = 6'b111100;
      else if (mp) exp_ctl = 6'b000011;
      else if (lu) exp_ctl = 6'b110001;
      else         exp_ctl = 6'b000000;
      chk("ctl", {26'd0, ctl_vec()}, {26'd0, exp_ctl});
      @(posedge clk);
      if (exp_ctl[5]) m_stall = (m_stall < SAT_MAX) ? m_stall + 1 : SAT_MAX;
      if (!busy && mp) m_flush = (m_flush < SAT_MAX) ? m_flush + 1 : SAT_MAX;
      // Error once a wait has already lasted MT cycles and is still pending
      if (m_wait && busy && m_busy_run >= MT) m_err = 1'b1;
      m_busy_run = busy ? m_busy_run + 1 : 0;
      m_wait     = busy;
      #1;
      chk("timeout_err", {31'd0, hz.timeout_err}, {31'd0, m_err});
      chk("stall_cycles", {28'd0, hz.stall_cycles}, 32'(m_stall));
      chk("flush_count", {28'd0, hz.flush_count}, 32'(m_flush));
   endtask

   initial begin
      rst            = 1'b1;
      hz.rs1_addrD   = '0;
      hz.rs2_addrD   = '0;
      hz.rdE         = '0;
      hz.MemReadE    = 1'b0;
      hz.mispredictE = 1'b0;
      hz.dmem_reqM   = 1'b1;
      hz.dmem_ready  = 1'b0;
      model_reset();
      #12;
      chk("por_ctl", {26'd0, ctl_vec()}, 32'd0);
      chk("por_cnt", {24'd0, hz.stall_cycles, hz.flush_count}, 32'd0);
      rst = 1'b0;

      // Load-use interlock, then rdE = x0 never interlocks
      step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_stall_cnt", {28'd0, hz.stall_cycles}, 32'd1);
      step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Mispredict wins over a simultaneous load-use
      do_reset();
      step(5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mp_flush_cnt", {28'd0, hz.flush_count}, 32'd1);

      // Three-cycle memory wait then ready
      do_reset();
      repeat (3) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("wait_stall_cnt", {28'd0, hz.stall_cycles}, 32'd3);

      // Mispredict held across a wait is flushed on the ready cycle
      do_reset();
      repeat (2) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("defer_flush_cnt", {28'd0, hz.flush_count}, 32'd1);

      // Timeout: long wait, flag sticks after ready, cleared by async reset
      do_reset();
      repeat (6) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("timeout_sticky", {31'd0, hz.timeout_err}, 32'd1);
      repeat (3) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      do_reset();
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Counter saturation
      repeat (20) step(5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stall_sat", {28'd0, hz.stall_cycles}, 32'(SAT_MAX));

      // Random traffic with small register ranges to provoke collisions
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) < ((i % 100 < 50) ? 6 : 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
